// File: rtl/victim_way_sel_if.sv
// ---------------------------------------------------------------------------
// victim_way_sel_if
// Handshake bundle between the miss handler (master) and the victim-way
// selector (slave).
//   req_valid_i / req_ready_o    miss request handshake
//   req_set_i                    set index of the miss
//   req_way_valid_i              per-way valid bits of that set
//   rsp_valid_o / rsp_ready_i    victim result handshake
//   rsp_set_o                    set index echoed from the request
//   rsp_way_bin_o / rsp_way_oh_o victim way, binary and one-hot
//   rsp_from_rr_o                1 = victim from round-robin pointer
// Signal suffixes are from the selector's point of view.
// ---------------------------------------------------------------------------
interface victim_way_sel_if #(
  parameter int WAY_NUM = 4,
  parameter int SET_NUM = 64
);
  localparam int WW = $clog2(WAY_NUM);
  localparam int SW = $clog2(SET_NUM);

  logic               req_valid_i;
  logic               req_ready_o;
  logic [SW-1:0]      req_set_i;
  logic [WAY_NUM-1:0] req_way_valid_i;
  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic [SW-1:0]      rsp_set_o;
  logic [WW-1:0]      rsp_way_bin_o;
  logic [WAY_NUM-1:0] rsp_way_oh_o;
  logic               rsp_from_rr_o;

  modport slave (
    input  req_valid_i, req_set_i, req_way_valid_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_set_o, rsp_way_bin_o,
           rsp_way_oh_o, rsp_from_rr_o
  );

  modport master (
    output req_valid_i, req_set_i, req_way_valid_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_set_o, rsp_way_bin_o,
           rsp_way_oh_o, rsp_from_rr_o
  );
endinterface

// File: rtl/victim_way_sel.sv
// ---------------------------------------------------------------------------
// victim_way_sel
// Replacement-victim selector for the cache fill path. On each accepted miss
// request it picks the lowest-numbered invalid way, or, when every way of the
// set is valid, the set's round-robin pointer (which then advances). The
// result is presented one cycle later through a single output register as a
// one-hot way-enable and a binary way index.
// Ports:
//   clk_i    clock, all state on the rising edge
//   rst_ni   asynchronous active-low reset
//   flush_i  synchronous clear of every round-robin pointer
//   bus      victim_way_sel_if.slave request/response handshake
// ---------------------------------------------------------------------------
module victim_way_sel #(
  parameter int WAY_NUM = 4,
  parameter int SET_NUM = 64,
  localparam int WW = $clog2(WAY_NUM),
  localparam int SW = $clog2(SET_NUM)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  victim_way_sel_if.slave       bus
);

  logic [WW-1:0]      rr_ptr_q [SET_NUM];

  logic               rsp_valid_q, rsp_valid_d;
  logic [SW-1:0]      rsp_set_q, rsp_set_d;
  logic [WW-1:0]      rsp_bin_q, rsp_bin_d;
  logic [WAY_NUM-1:0] rsp_oh_q, rsp_oh_d;
  logic               rsp_rr_q, rsp_rr_d;

  logic               req_ready;
  logic               accept;
  logic               all_valid;
  logic [WW-1:0]      inv_bin;
  logic [WW-1:0]      victim_bin;
  logic [WAY_NUM-1:0] victim_oh;

  // Full-throughput single stage: a new request may enter in the same cycle
  // the held result is consumed.
  assign req_ready = !rsp_valid_q || bus.rsp_ready_i;
  assign accept    = bus.req_valid_i && req_ready;
  assign all_valid = &bus.req_way_valid_i;

  // Lowest invalid way: scan from the top so the lowest index wins last.
  always_comb begin
    inv_bin = '0;
    for (int i = WAY_NUM - 1; i >= 0; i--) begin
      if (!bus.req_way_valid_i[i]) inv_bin = WW'(i);
    end
  end

  // One decision feeds both encodings, so they can never disagree.
  always_comb begin
    victim_bin            = all_valid ? rr_ptr_q[bus.req_set_i] : inv_bin;
    victim_oh             = '0;
    victim_oh[victim_bin] = 1'b1;
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_set_d   = rsp_set_q;
    rsp_bin_d   = rsp_bin_q;
    rsp_oh_d    = rsp_oh_q;
    rsp_rr_d    = rsp_rr_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_set_d   = bus.req_set_i;
      rsp_bin_d   = victim_bin;
      rsp_oh_d    = victim_oh;
      rsp_rr_d    = all_valid;
    end else if (bus.rsp_ready_i) begin
      // Payload is left as-is once consumed; only valid drops.
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_set_q   <= '0;
      rsp_bin_q   <= '0;
      rsp_oh_q    <= '0;
      rsp_rr_q    <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_set_q   <= rsp_set_d;
      rsp_bin_q   <= rsp_bin_d;
      rsp_oh_q    <= rsp_oh_d;
      rsp_rr_q    <= rsp_rr_d;
    end
  end

  // Pointer advances at accept (not at response) so back-to-back requests to
  // one set get consecutive ways. Flush has priority over the increment; the
  // victim of a simultaneous request has already used the pre-flush value.
  // Pointer width is exactly WW bits, so the +1 wraps WAY_NUM-1 to 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SET_NUM; s++) rr_ptr_q[s] <= '0;
    end else if (flush_i) begin
      for (int s = 0; s < SET_NUM; s++) rr_ptr_q[s] <= '0;
    end else if (accept && all_valid) begin
      rr_ptr_q[bus.req_set_i] <= rr_ptr_q[bus.req_set_i] + WW'(1);
    end
  end

  assign bus.req_ready_o   = req_ready;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_set_o     = rsp_set_q;
  assign bus.rsp_way_bin_o = rsp_bin_q;
  assign bus.rsp_way_oh_o  = rsp_oh_q;
  assign bus.rsp_from_rr_o = rsp_rr_q;

endmodule

// File: tb/tb_victim_way_sel.sv
// ---------------------------------------------------------------------------
// tb_victim_way_sel
// Self-checking bench for victim_way_sel (WAY_NUM=4, SET_NUM=64): directed
// vector table, a reset-while-stalled sequence, then randomized traffic, all
// also compared against a behavioural model of the selection rules.
// ---------------------------------------------------------------------------
module tb_victim_way_sel;
  localparam int WAY = 4;
  localparam int SET = 64;

  logic clk;
  logic rst_n;
  logic flush;

  victim_way_sel_if #(.WAY_NUM(WAY), .SET_NUM(SET)) bus ();

  victim_way_sel #(.WAY_NUM(WAY), .SET_NUM(SET)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  int         m_ptr [SET];
  logic       m_vld;
  logic [5:0] m_set;
  logic [1:0] m_bin;
  logic [3:0] m_oh;
  logic       m_rr;

  typedef struct {
    logic       v;
    logic [5:0] set;
    logic [3:0] wv;
    logic       rdy;
    logic       fl;
    logic       e_vld;
    logic [5:0] e_set;
    logic [1:0] e_bin;
    logic [3:0] e_oh;
    logic       e_rr;
    logic       e_rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input logic [5:0] set, input logic [3:0] wv,
                     input logic rdy, input logic fl, input logic e_vld,
                     input logic [5:0] e_set, input logic [1:0] e_bin,
                     input logic [3:0] e_oh, input logic e_rr, input logic e_rdy);
    vec_t r;
    r.v = v; r.set = set; r.wv = wv; r.rdy = rdy; r.fl = fl;
    r.e_vld = e_vld; r.e_set = e_set; r.e_bin = e_bin; r.e_oh = e_oh;
    r.e_rr = e_rr; r.e_rdy = e_rdy;
    tbl.push_back(r);
  endtask

  task automatic drive(input logic v, input logic [5:0] set, input logic [3:0] wv,
                       input logic rdy, input logic fl);
    bus.req_valid_i     = v;
    bus.req_set_i       = set;
    bus.req_way_valid_i = wv;
    bus.rsp_ready_i     = rdy;
    flush               = fl;
  endtask

  task automatic model_reset();
    for (int s = 0; s < SET; s++) m_ptr[s] = 0;
    m_vld = 1'b0; m_set = '0; m_bin = '0; m_oh = '0; m_rr = 1'b0;
  endtask

  task automatic cmp_model();
    chk("mdl_vld",   32'(bus.rsp_valid_o),   32'(m_vld));
    chk("mdl_set",   32'(bus.rsp_set_o),     32'(m_set));
    chk("mdl_bin",   32'(bus.rsp_way_bin_o), 32'(m_bin));
    chk("mdl_oh",    32'(bus.rsp_way_oh_o),  32'(m_oh));
    chk("mdl_rr",    32'(bus.rsp_from_rr_o), 32'(m_rr));
    chk("mdl_ready", 32'(bus.req_ready_o),   32'(!m_vld || bus.rsp_ready_i));
  endtask

  // One clock: model follows the rules at the edge, outputs sampled 1ns later.
  task automatic step();
    logic ready;
    int   victim;
    @(posedge clk);
    ready = !m_vld || bus.rsp_ready_i;
    if (bus.req_valid_i && ready) begin
      victim = -1;
      for (int w = 0; w < WAY; w++)
        if (victim < 0 && !bus.req_way_valid_i[w]) victim = w;
      m_rr = (victim < 0);
      if (victim < 0) begin
        victim = m_ptr[bus.req_set_i];
        m_ptr[bus.req_set_i] = (m_ptr[bus.req_set_i] + 1) % WAY;
      end
      m_vld = 1'b1;
      m_set = bus.req_set_i;
      m_bin = 2'(victim);
      m_oh  = 4'(1 << victim);
    end else if (bus.rsp_ready_i) begin
      m_vld = 1'b0;
    end
    if (flush) for (int s = 0; s < SET; s++) m_ptr[s] = 0;
    #1;
    cmp_model();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    model_reset();

    // Directed vectors: v set wv rdy fl | vld set bin oh rr ready
    add(1, 5, 4'hF, 1, 0,  1, 5, 0, 4'h1, 1, 1);
    add(1, 3, 4'hB, 1, 0,  1, 3, 2, 4'h4, 0, 1);
    add(1, 3, 4'hF, 1, 0,  1, 3, 0, 4'h1, 1, 1);
    add(1, 7, 4'hF, 1, 0,  1, 7, 0, 4'h1, 1, 1);
    add(1, 7, 4'hF, 1, 0,  1, 7, 1, 4'h2, 1, 1);
    add(1, 7, 4'hF, 1, 0,  1, 7, 2, 4'h4, 1, 1);
    add(1, 7, 4'hF, 1, 0,  1, 7, 3, 4'h8, 1, 1);
    add(1, 7, 4'hF, 1, 0,  1, 7, 0, 4'h1, 1, 1);
    add(1, 1, 4'hF, 1, 0,  1, 1, 0, 4'h1, 1, 1);
    add(1, 2, 4'hF, 1, 0,  1, 2, 0, 4'h1, 1, 1);
    add(1, 1, 4'hF, 1, 0,  1, 1, 1, 4'h2, 1, 1);
    add(1, 2, 4'hF, 1, 0,  1, 2, 1, 4'h2, 1, 1);
    add(1, 1, 4'hF, 1, 0,  1, 1, 2, 4'h4, 1, 1);
    add(1, 2, 4'hF, 1, 0,  1, 2, 2, 4'h4, 1, 1);
    add(0, 0, 4'h0, 1, 0,  0, 2, 2, 4'h4, 1, 1);
    add(1, 4, 4'hF, 1, 0,  1, 4, 0, 4'h1, 1, 1);
    add(1, 4, 4'hF, 1, 0,  1, 4, 1, 4'h2, 1, 1);
    add(1, 9, 4'hF, 1, 0,  1, 9, 0, 4'h1, 1, 1);
    add(1, 9, 4'hF, 0, 0,  1, 9, 0, 4'h1, 1, 0);
    add(1, 9, 4'hF, 0, 0,  1, 9, 0, 4'h1, 1, 0);
    add(1, 9, 4'hF, 0, 0,  1, 9, 0, 4'h1, 1, 0);
    add(1, 9, 4'hF, 1, 0,  1, 9, 1, 4'h2, 1, 1);
    add(1, 4, 4'hF, 1, 1,  1, 4, 2, 4'h4, 1, 1);
    add(1, 4, 4'hF, 1, 0,  1, 4, 0, 4'h1, 1, 1);
    add(1, 5, 4'hF, 1, 0,  1, 5, 0, 4'h1, 1, 1);
    add(1, 9, 4'hF, 1, 0,  1, 9, 0, 4'h1, 1, 1);
    add(1, 6, 4'h0, 1, 0,  1, 6, 0, 4'h1, 0, 1);
    add(1, 6, 4'h7, 1, 0,  1, 6, 3, 4'h8, 0, 1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld",   32'(bus.rsp_valid_o),   32'd0);
    chk("rst_oh",    32'(bus.rsp_way_oh_o),  32'd0);
    chk("rst_bin",   32'(bus.rsp_way_bin_o), 32'd0);
    chk("rst_set",   32'(bus.rsp_set_o),     32'd0);
    chk("rst_rr",    32'(bus.rsp_from_rr_o), 32'd0);
    chk("rst_ready", 32'(bus.req_ready_o),   32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].set, tbl[i].wv, tbl[i].rdy, tbl[i].fl);
      step();
      chk($sformatf("vec%0d_vld", i),   32'(bus.rsp_valid_o),   32'(tbl[i].e_vld));
      chk($sformatf("vec%0d_set", i),   32'(bus.rsp_set_o),     32'(tbl[i].e_set));
      chk($sformatf("vec%0d_bin", i),   32'(bus.rsp_way_bin_o), 32'(tbl[i].e_bin));
      chk($sformatf("vec%0d_oh", i),    32'(bus.rsp_way_oh_o),  32'(tbl[i].e_oh));
      chk($sformatf("vec%0d_rr", i),    32'(bus.rsp_from_rr_o), 32'(tbl[i].e_rr));
      chk($sformatf("vec%0d_ready", i), 32'(bus.req_ready_o),   32'(tbl[i].e_rdy));
    end

    // Reset asserted while a result is stalled: valid drops without a clock.
    drive(1, 5, 4'hF, 1, 0);
    step();
    drive(1, 8, 4'hF, 0, 0);
    step();
    step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_vld",   32'(bus.rsp_valid_o),  32'd0);
    chk("rst_mid_oh",    32'(bus.rsp_way_oh_o), 32'd0);
    chk("rst_mid_ready", 32'(bus.req_ready_o),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 4'h0, 1, 0);
    step();
    chk("post_rst_vld", 32'(bus.rsp_valid_o), 32'd0);
    drive(1, 5, 4'hF, 1, 0);
    step();
    chk("post_rst_bin", 32'(bus.rsp_way_bin_o), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [5:0] s;
      logic [3:0] wv;
      s  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 3));
      wv = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      drive($urandom_range(0, 3) != 0, s, wv,
            $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
